// File: rtl/gate_lane_arbiter.sv
// Round-robin owner of the single parking gate, shared by the entry and exit lanes.
// Sequences open -> pass -> close with a forced close on timeout and keeps lot occupancy.
module gate_lane_arbiter #(
  parameter int CAPACITY     = 8,
  parameter int CNT_W        = 4,
  parameter int OPEN_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_in,
  input  logic             req_out,
  input  logic             pass_in,
  input  logic             pass_out,
  input  logic             gate_block,
  output logic             grant_in,
  output logic             grant_out,
  output logic             gate_open,
  output logic             gate_close,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             timeout_alarm
);

  localparam int TMR_W = $clog2(OPEN_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(OPEN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(CAPACITY);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPEN_IN,
    ST_OPEN_OUT,
    ST_CLOSING,
    ST_BLOCKED
  } state_e;

  typedef enum logic {
    LANE_IN,
    LANE_OUT
  } lane_e;

  state_e           state_q, state_d;
  lane_e            last_q, last_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             alarm_q, alarm_d;

  logic elig_in;
  logic elig_out;

  assign full      = (occ_q == CNT_CAP);
  assign empty     = (occ_q == '0);
  assign occupancy = occ_q;
  assign elig_in   = req_in && !full;
  assign elig_out  = req_out && !empty;

  // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    timer_d = timer_q;
    occ_d   = occ_q;
    alarm_d = 1'b0;

    // A block wins over passage and timeout; a coincident passage is dropped.
    if (gate_block) begin
      state_d = ST_BLOCKED;
      timer_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          timer_d = '0;
          if (elig_in && elig_out) begin
            if (last_q == LANE_OUT) begin
              state_d = ST_OPEN_IN;
              last_d  = LANE_IN;
            end else begin
              state_d = ST_OPEN_OUT;
              last_d  = LANE_OUT;
            end
          end else if (elig_in) begin
            state_d = ST_OPEN_IN;
          end else if (elig_out) begin
            state_d = ST_OPEN_OUT;
          end
        end

        ST_OPEN_IN: begin
          if (pass_in) begin
            state_d = ST_CLOSING;
            occ_d   = occ_q + CNT_W'(1);
          end else if (timer_q == TMR_LAST) begin
            state_d = ST_CLOSING;
            alarm_d = 1'b1;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end

        ST_OPEN_OUT: begin
          if (pass_out) begin
            state_d = ST_CLOSING;
            occ_d   = occ_q - CNT_W'(1);
          end else if (timer_q == TMR_LAST) begin
            state_d = ST_CLOSING;
            alarm_d = 1'b1;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end

        ST_CLOSING: state_d = ST_IDLE;
        ST_BLOCKED: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= LANE_OUT;
      timer_q <= '0;
      occ_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      occ_q   <= occ_d;
      alarm_q <= alarm_d;
    end
  end

  always_comb begin
    grant_in      = 1'b0;
    grant_out     = 1'b0;
    gate_open     = 1'b0;
    gate_close    = 1'b0;
    timeout_alarm = 1'b0;
    unique case (state_q)
      ST_OPEN_IN: begin
        grant_in  = 1'b1;
        gate_open = 1'b1;
      end
      ST_OPEN_OUT: begin
        grant_out = 1'b1;
        gate_open = 1'b1;
      end
      ST_CLOSING: begin
        gate_close    = 1'b1;
        timeout_alarm = alarm_q;
      end
      ST_BLOCKED: gate_close = 1'b1;
      default: ;
    endcase
  end

endmodule
